// File: rtl/sap_controller.sv
// sap_controller
//   Controller-sequencer for the SAP-1 datapath. A one-hot six-state ring
//   (T1..T6) sequences fetch and execute; each state plus the opcode is
//   decoded into the 12-bit control word for the W-bus datapath.
//
// Ports
//   clock        in   1   system clock, rising-edge active
//   reset        in   1   asynchronous, active-low reset
//   instruction  in   4   opcode (upper nibble of the instruction register)
//   con          out 12   {Cp,Ep,Lm_n,Ce_n, Li_n,Ei,La_n,Ea, Su,Eu,Lb_n,Lo_n}
//   t_state      out  6   one-hot ring state, bit 0 = T1 .. bit 5 = T6
//   halt         out  1   set once HLT executes, cleared only by reset
//
// Build option
//   SAP_VAR_CYCLE_EN  variable machine cycle: NOP/OUT return to T1 after T4,
//                     LDA after T5, ADD/SUB after T6. Undefined: every
//                     instruction occupies T1..T6.

module sap_controller (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  instruction,
    output logic [11:0] con,
    output logic [5:0]  t_state,
    output logic        halt
);

    typedef enum logic [5:0] {
        ST_T1 = 6'b000001,
        ST_T2 = 6'b000010,
        ST_T3 = 6'b000100,
        ST_T4 = 6'b001000,
        ST_T5 = 6'b010000,
        ST_T6 = 6'b100000
    } ring_t;

    typedef enum logic [3:0] {
        OP_LDA = 4'h0,
        OP_ADD = 4'h1,
        OP_SUB = 4'h2,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_t;

    localparam logic [11:0] CON_IDLE = 12'h3A3;

    // Ring kept as a plain vector so that non-one-hot values remain
    // representable and recover through the default branch.
    logic [5:0] r_ring;
    logic [5:0] w_ring_next;
    logic       r_halt;
    logic       w_halt_next;
    logic       r_run;      // low for the first edge after reset release
    logic       w_is_nop;
    logic       w_t4_last;
    logic       w_t5_last;

    assign w_is_nop = !(instruction inside {OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT});

`ifdef SAP_VAR_CYCLE_EN
    assign w_t4_last = w_is_nop || (instruction == OP_OUT);
    assign w_t5_last = (instruction == OP_LDA);
`else
    assign w_t4_last = 1'b0;
    assign w_t5_last = 1'b0;
`endif

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ring <= ST_T1;
            r_halt <= 1'b0;
            r_run  <= 1'b0;
        end else begin
            r_ring <= w_ring_next;
            r_halt <= w_halt_next;
            r_run  <= 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        w_ring_next = r_ring;
        w_halt_next = r_halt;
        // The first edge after reset release holds T1; halted freezes at T4.
        if (r_run && !r_halt) begin
            case (r_ring)
                ST_T1: w_ring_next = ST_T2;
                ST_T2: w_ring_next = ST_T3;
                ST_T3: w_ring_next = ST_T4;
                ST_T4: begin
                    if (instruction == OP_HLT) begin
                        w_halt_next = 1'b1;
                        w_ring_next = ST_T4;
                    end else if (w_t4_last) begin
                        w_ring_next = ST_T1;
                    end else begin
                        w_ring_next = ST_T5;
                    end
                end
                ST_T5:   w_ring_next = w_t5_last ? ST_T1 : ST_T6;
                ST_T6:   w_ring_next = ST_T1;
                default: w_ring_next = ST_T1;
            endcase
        end
    end

    // Output decode; reset forces the idle word even though the ring shows T1.
    always_comb begin
        con = CON_IDLE;
        if (reset && !r_halt) begin
            case (r_ring)
                ST_T1: con = 12'h5A3;           // Ep, Lm_n
                ST_T2: con = 12'hBA3;           // Cp
                ST_T3: con = 12'h223;           // Ce_n, Li_n
                ST_T4: begin
                    case (instruction)
                        OP_LDA, OP_ADD, OP_SUB: con = 12'h1E3;  // Ei, Lm_n
                        OP_OUT:                 con = 12'h3B2;  // Ea, Lo_n
                        default:                con = CON_IDLE;
                    endcase
                end
                ST_T5: begin
                    case (instruction)
                        OP_LDA:         con = 12'h283;  // Ce_n, La_n
                        OP_ADD, OP_SUB: con = 12'h2A1;  // Ce_n, Lb_n
                        default:        con = CON_IDLE;
                    endcase
                end
                ST_T6: begin
                    case (instruction)
                        OP_ADD:  con = 12'h387;         // La_n, Eu
                        OP_SUB:  con = 12'h38F;         // La_n, Su, Eu
                        default: con = CON_IDLE;
                    endcase
                end
                default: con = CON_IDLE;
            endcase
        end
    end

    assign t_state = r_ring;
    assign halt    = r_halt;

endmodule

// File: tb/tb_sap_controller.sv
// Self-checking bench for sap_controller: expectations are queued when a
// step is driven and compared when the DUT outputs are sampled.

module tb_sap_controller;

    logic        clock;
    logic        reset;
    logic [3:0]  instruction;
    logic [11:0] con;
    logic [5:0]  t_state;
    logic        halt;

    typedef struct {
        string       tag;
        logic [11:0] con;
        logic [5:0]  t;
        logic        h;
    } exp_t;

    exp_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    sap_controller dut (
        .clock       (clock),
        .reset       (reset),
        .instruction (instruction),
        .con         (con),
        .t_state     (t_state),
        .halt        (halt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T4 = 6'b001000;

    function automatic logic [5:0] onehot(input int k);
        logic [5:0] one;
        one = 6'b000001;
        return one << (k - 1);
    endfunction

    // Expected execute word for state Tk (k = 4..6)
    function automatic logic [11:0] exec_word(input logic [3:0] op, input int k);
        case (op)
            4'h0:    return (k == 4) ? 12'h1E3 : (k == 5) ? 12'h283 : 12'h3A3;
            4'h1:    return (k == 4) ? 12'h1E3 : (k == 5) ? 12'h2A1 : 12'h387;
            4'h2:    return (k == 4) ? 12'h1E3 : (k == 5) ? 12'h2A1 : 12'h38F;
            4'hE:    return (k == 4) ? 12'h3B2 : 12'h3A3;
            default: return 12'h3A3;
        endcase
    endfunction

    function automatic int last_state(input logic [3:0] op);
`ifdef SAP_VAR_CYCLE_EN
        case (op)
            4'h0:       return 5;
            4'h1, 4'h2: return 6;
            default:    return 4;
        endcase
`else
        return 6 + 0 * op;
`endif
    endfunction

    task automatic cmp_bits(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic check_front();
        exp_t e;
        if (q.size() == 0) begin
            n_total++;
            $error("FAIL scoreboard: got empty queue expected entry");
            return;
        end
        e = q.pop_front();
        cmp_bits({e.tag, ".con"},  con,              e.con);
        cmp_bits({e.tag, ".t"},    {6'b0, t_state},  {6'b0, e.t});
        cmp_bits({e.tag, ".halt"}, {11'b0, halt},    {11'b0, e.h});
    endtask

    // Compare the current (asynchronous/combinational) outputs.
    task automatic expect_now(input string tag, input logic [11:0] c, input logic [5:0] t, input logic h);
        q.push_back('{tag, c, t, h});
        #1;
        check_front();
    endtask

    // One clock: queue the expectation after the edge, compare at the falling edge.
    task automatic step(input string tag, input logic [11:0] c, input logic [5:0] t, input logic h);
        @(posedge clock);
        #2;
        q.push_back('{tag, c, t, h});
        @(negedge clock);
        check_front();
    endtask

    // Called while in T1; runs T2..last and the return to T1.
    task automatic run_instr(input string tag, input logic [3:0] op);
        instruction = op;
        step({tag, ".T2"}, 12'hBA3, 6'b000010, 1'b0);
        step({tag, ".T3"}, 12'h223, 6'b000100, 1'b0);
        for (int k = 4; k <= last_state(op); k++)
            step($sformatf("%s.T%0d", tag, k), exec_word(op, k), onehot(k), 1'b0);
        step({tag, ".T1"}, 12'h5A3, T1, 1'b0);
    endtask

    initial begin
        reset       = 1'b0;
        instruction = 4'h0;

        // Reset held low for three clocks
        repeat (3) @(negedge clock);
        expect_now("rst_low", 12'h3A3, T1, 1'b0);
        reset = 1'b1;
        expect_now("rst_rel", 12'h5A3, T1, 1'b0);
        step("hold_T1", 12'h5A3, T1, 1'b0);

        run_instr("LDA", 4'h0);
        run_instr("ADD", 4'h1);
        run_instr("SUB", 4'h2);
        run_instr("OUT", 4'hE);
        run_instr("NOP", 4'h7);
        run_instr("LDA2", 4'h0);
        run_instr("ADD2", 4'h1);

        // Illegal ring value injected during T2 recovers to T1
        instruction = 4'h1;
        step("inj.T2", 12'hBA3, 6'b000010, 1'b0);
        force dut.r_ring = 6'b000110;
        #1;
        release dut.r_ring;
        step("inj.T1", 12'h5A3, T1, 1'b0);

        // HLT: freezes at T4 with the idle word
        instruction = 4'hF;
        step("HLT.T2", 12'hBA3, 6'b000010, 1'b0);
        step("HLT.T3", 12'h223, 6'b000100, 1'b0);
        step("HLT.T4", 12'h3A3, T4, 1'b0);
        for (int i = 0; i < 20; i++)
            step($sformatf("halted%0d", i), 12'h3A3, T4, 1'b1);

        reset = 1'b0;
        expect_now("halt_rst", 12'h3A3, T1, 1'b0);
        reset = 1'b1;
        expect_now("halt_rel", 12'h5A3, T1, 1'b0);
        step("hold2", 12'h5A3, T1, 1'b0);

        // Reset asserted in T5 of an ADD aborts at once
        instruction = 4'h1;
        step("mid.T2", 12'hBA3, 6'b000010, 1'b0);
        step("mid.T3", 12'h223, 6'b000100, 1'b0);
        step("mid.T4", 12'h1E3, T4, 1'b0);
        step("mid.T5", 12'h2A1, 6'b010000, 1'b0);
        reset = 1'b0;
        expect_now("mid_rst", 12'h3A3, T1, 1'b0);
        reset = 1'b1;
        expect_now("mid_rel", 12'h5A3, T1, 1'b0);
        step("hold3", 12'h5A3, T1, 1'b0);
        run_instr("SUB2", 4'h2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global time bound so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout: got no completion expected finish");
        $fatal(1, "timeout");
    end

endmodule
